// File: rtl/seq_md_alu.sv
// Sequential ALU: single-cycle integer ops plus iterative shift-add multiply and restoring divide.
// Latency: 1 cycle for ALU ops and divide-by-zero; WIDTH+1 cycles for MUL/MULHU/DIV/DIVU/REM/REMU.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_valid && out_ready.
module seq_md_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Opsel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUop,
    output logic             zero_flag,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       op_q;        // bit0: MULHU vs MUL, bit1: remainder vs quotient
    logic             neg_q, neg_r;
    logic [WIDTH-1:0] p_hi, p_lo;  // product {hi,lo}, or {remainder, dividend/quotient}
    logic [WIDTH-1:0] opnd;        // multiplicand or divisor magnitude
    logic [CW-1:0]    cnt;

    logic             ld_res;
    logic [WIDTH-1:0] res_nxt, simple_res;

    // request decode
    logic             is_mul, is_div, div_signed, b_zero, last;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign is_mul     = (Opsel[3:1] == 3'b101);
    assign is_div     = (Opsel[3:2] == 2'b11);
    assign div_signed = is_div && !Opsel[0];
    assign b_zero     = (B == '0);
    assign a_mag      = (div_signed && A[WIDTH-1]) ? -A : A;
    assign b_mag      = (div_signed && B[WIDTH-1]) ? -B : B;
    assign last       = (cnt == CW'(WIDTH-1));

    // one shift-add step: conditionally add multiplicand to the high half, then shift right
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nxt, mul_lo_nxt;
    assign mul_sum                  = {1'b0, p_hi} + (p_lo[0] ? {1'b0, opnd} : '0);
    assign {mul_hi_nxt, mul_lo_nxt} = {mul_sum, p_lo[WIDTH-1:1]};

    // one restoring-divide step: shift in next dividend bit, subtract if it fits
    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_trial, div_hi_nxt, div_lo_nxt, quo_fix, rem_fix;
    assign div_sh     = {p_hi, p_lo[WIDTH-1]};
    assign div_ok     = (div_sh >= {1'b0, opnd});
    assign div_trial  = div_sh[WIDTH-1:0] - opnd;
    assign div_hi_nxt = div_ok ? div_trial : div_sh[WIDTH-1:0];
    assign div_lo_nxt = {p_lo[WIDTH-2:0], div_ok};
    assign quo_fix    = neg_q ? -div_lo_nxt : div_lo_nxt;
    assign rem_fix    = neg_r ? -div_hi_nxt : div_hi_nxt;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // single-cycle results, including the divide-by-zero shortcut
    always_comb begin
        simple_res = '0;
        case (Opsel)
            4'b0000: simple_res = A + B;
            4'b0001: simple_res = A - B;
            4'b0010: simple_res = A & B;
            4'b0011: simple_res = A | B;
            4'b0100: simple_res = A ^ B;
            4'b0101: simple_res = A << B[SHW-1:0];
            4'b0110: simple_res = A >> B[SHW-1:0];
            4'b0111: simple_res = WIDTH'($signed(A) >>> B[SHW-1:0]);
            4'b1000: simple_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b1001: simple_res = {{(WIDTH-1){1'b0}}, A < B};
            4'b1100, 4'b1101: simple_res = '1;
            4'b1110, 4'b1111: simple_res = A;
            default: simple_res = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and result load on entry to DONE
    always_comb begin
        state_nxt = state;
        ld_res    = 1'b0;
        res_nxt   = '0;
        case (state)
            IDLE: if (in_valid) begin
                if (is_mul)                 state_nxt = MUL;
                else if (is_div && !b_zero) state_nxt = DIV;
                else begin
                    state_nxt = DONE;
                    ld_res    = 1'b1;
                    res_nxt   = simple_res;
                end
            end
            MUL: if (last) begin
                state_nxt = DONE;
                ld_res    = 1'b1;
                res_nxt   = op_q[0] ? mul_hi_nxt : mul_lo_nxt;
            end
            DIV: if (last) begin
                state_nxt = DONE;
                ld_res    = 1'b1;
                res_nxt   = op_q[1] ? rem_fix : quo_fix;
            end
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // operand capture, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            p_hi      <= '0;
            p_lo      <= '0;
            opnd      <= '0;
            cnt       <= '0;
            ALUop     <= '0;
            zero_flag <= 1'b1;
        end else begin
            if (ld_res) begin
                ALUop     <= res_nxt;
                zero_flag <= (res_nxt == '0);
            end
            case (state)
                IDLE: if (in_valid) begin
                    op_q  <= Opsel[1:0];
                    cnt   <= '0;
                    p_hi  <= '0;
                    neg_q <= div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                    neg_r <= div_signed && A[WIDTH-1];
                    if (is_div) begin
                        p_lo <= a_mag;
                        opnd <= b_mag;
                    end else begin
                        p_lo <= B;
                        opnd <= A;
                    end
                end
                MUL: begin
                    p_hi <= mul_hi_nxt;
                    p_lo <= mul_lo_nxt;
                    cnt  <= cnt + CW'(1);
                end
                DIV: begin
                    p_hi <= div_hi_nxt;
                    p_lo <= div_lo_nxt;
                    cnt  <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_md_alu.sv
module tb_seq_md_alu;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, zero_flag, busy;
    logic [31:0] A, B, ALUop;
    logic [3:0]  Opsel;

    int passed = 0;
    int total  = 0;

    seq_md_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Opsel(Opsel), .out_valid(out_valid), .out_ready(out_ready),
        .ALUop(ALUop), .zero_flag(zero_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 30;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // wait for in_ready, present one request, return result, flag and latency in edges
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zf, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL ready_timeout: in_ready stuck at 0");
        end
        in_valid = 1'b1; Opsel = op; A = a; B = b;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; Opsel = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = ALUop;
        zf  = zero_flag;
    endtask

    initial begin
        logic [31:0] res;
        logic        zf;
        int          lat, w, bad_v, bad_d, bad_r, seen;

        vecs[0]  = '{4'h0, 32'd22, 32'd32, 32'd54, 1};
        vecs[1]  = '{4'h1, 32'd22, 32'd32, 32'hFFFFFFF6, 1};
        vecs[2]  = '{4'h2, 32'd22, 32'd32, 32'd0, 1};
        vecs[3]  = '{4'h3, 32'd22, 32'd32, 32'd54, 1};
        vecs[4]  = '{4'h4, 32'd22, 32'd32, 32'd54, 1};
        vecs[5]  = '{4'h5, 32'd22, 32'd32, 32'd22, 1};
        vecs[6]  = '{4'h6, 32'd22, 32'd32, 32'd22, 1};
        vecs[7]  = '{4'h7, 32'd22, 32'd32, 32'd22, 1};
        vecs[8]  = '{4'h8, 32'd22, 32'd32, 32'd1, 1};
        vecs[9]  = '{4'h9, 32'd22, 32'd32, 32'd1, 1};
        vecs[10] = '{4'hA, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 33};
        vecs[11] = '{4'hB, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33};
        vecs[12] = '{4'hC, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33};
        vecs[13] = '{4'hE, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33};
        vecs[14] = '{4'hD, 32'd7, 32'd0, 32'hFFFFFFFF, 1};
        vecs[15] = '{4'hF, 32'd7, 32'd0, 32'd7, 1};
        vecs[16] = '{4'hC, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vecs[17] = '{4'hE, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33};
        vecs[18] = '{4'h5, 32'd1, 32'd35, 32'd8, 1};
        vecs[19] = '{4'h7, 32'h80000000, 32'd4, 32'hF8000000, 1};
        vecs[20] = '{4'hD, 32'd100, 32'd7, 32'd14, 33};
        vecs[21] = '{4'hF, 32'd100, 32'd7, 32'd2, 33};
        vecs[22] = '{4'hC, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vecs[23] = '{4'hE, 32'd7, 32'hFFFFFFFE, 32'd1, 33};
        vecs[24] = '{4'h8, 32'hFFFFFFFF, 32'd1, 32'd1, 1};
        vecs[25] = '{4'h9, 32'hFFFFFFFF, 32'd1, 32'd0, 1};
        vecs[26] = '{4'hC, 32'd5, 32'd0, 32'hFFFFFFFF, 1};
        vecs[27] = '{4'hE, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1};
        vecs[28] = '{4'hA, 32'h00012345, 32'd0, 32'd0, 33};
        vecs[29] = '{4'hB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};

        // reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; Opsel = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_aluop", ALUop, 32'd0);
        chk("rst_zero_flag", {31'd0, zero_flag}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // table-driven operations
        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, zf, lat);
            chk($sformatf("v%0d_result", i), res, vecs[i].exp);
            chk($sformatf("v%0d_zero_flag", i), {31'd0, zf}, {31'd0, vecs[i].exp == 32'd0});
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // stall in DONE with requests pulsed during DIV and during the stall
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        out_ready = 1'b0;
        in_valid = 1'b1; Opsel = 4'hD; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b1; Opsel = 4'h0; A = 32'd1; B = 32'd2;
        @(posedge clk); #1;
        chk("div_pulse_in_ready", {31'd0, in_ready}, 32'd0);
        chk("div_pulse_busy", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 100) begin @(posedge clk); #1; w++; end
        chk("stall_result", ALUop, 32'd14);
        in_valid = 1'b1; Opsel = 4'h0; A = 32'd1; B = 32'd2;
        bad_v = 0; bad_d = 0; bad_r = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1) bad_v++;
            if (ALUop !== 32'd14) bad_d++;
            if (in_ready !== 1'b0) bad_r++;
        end
        chk("stall_out_valid_drops", 32'(bad_v), 32'd0);
        chk("stall_aluop_changes", 32'(bad_d), 32'd0);
        chk("stall_in_ready_highs", 32'(bad_r), 32'd0);
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk); #1;
        chk("handoff_out_valid", {31'd0, out_valid}, 32'd0);
        chk("handoff_in_ready", {31'd0, in_ready}, 32'd1);
        chk("handoff_aluop", ALUop, 32'd14);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("after_handoff_valid", {31'd0, out_valid}, 32'd1);
        chk("after_handoff_result", ALUop, 32'd3);

        // reset ten cycles into a DIV
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        in_valid = 1'b1; Opsel = 4'hC; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_div_aluop_held", ALUop, 32'd3);
        chk("mid_div_busy", {31'd0, busy}, 32'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("div_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("div_rst_aluop", ALUop, 32'd0);
        chk("div_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("div_rst_zero_flag", {31'd0, zero_flag}, 32'd1);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("div_rst_no_result", 32'(seen), 32'd0);
        run_op(4'h0, 32'd5, 32'd6, res, zf, lat);
        chk("post_rst_add", res, 32'd11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
